flex_counter_updown: RTL

//  Next-generation parametrised flex counter for the USB TX/RX datapath timing
//  (bit-period, byte and packet-length counting).
//  - Adds up/down counting, synchronous load, wrap vs saturate mode and a one-cycle wrap pulse.
//  - Optionally adds a prescaler, so one instance can generate bit-rate ticks and count them.

---
 rtl/flex_counter_updown.sv | 98 +++++++++
 1 files changed

// File: rtl/flex_counter_updown.sv
// rtl/flex_counter_updown.sv - up/down flex counter with load, wrap/saturate and wrap pulse
// Optional prescaler enabled by defining FLEX_CNT_PRESCALE_EN.
module flex_counter_updown #(
  parameter int NUM_CNT_BITS = 8,
  parameter int PRE_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_down,
  input  logic                    saturate,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
`ifdef FLEX_CNT_PRESCALE_EN
  input  logic [PRE_BITS-1:0]     prescale_val,
`endif
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  if (NUM_CNT_BITS < 2 || PRE_BITS < 1) begin : g_param_check
    $error("flex_counter_updown: NUM_CNT_BITS must be >= 2 and PRE_BITS >= 1");
  end

  logic [NUM_CNT_BITS-1:0] term;
  logic [NUM_CNT_BITS-1:0] step_cnt;
  logic                    step_wrap;
  logic                    do_step;

`ifdef FLEX_CNT_PRESCALE_EN
  logic [PRE_BITS-1:0] pre_q;

  assign do_step = count_enable && (pre_q == prescale_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      pre_q <= '0;
    else if (clear || load)
      pre_q <= '0;
    else if (count_enable)
      pre_q <= (pre_q == prescale_val) ? '0 : pre_q + 1'b1;
  end
`else
  assign do_step = count_enable;
`endif

  // Terminal value follows the direction being requested this cycle.
  assign term = count_down ? ONE : rollover_val;

  always_comb begin
    step_cnt  = count_out;
    step_wrap = 1'b0;
    if (!count_down) begin
      if (count_out < rollover_val) begin
        step_cnt = count_out + 1'b1;
      end else if (!saturate) begin
        step_cnt  = ONE;
        step_wrap = 1'b1;
      end
    end else begin
      if (count_out > ONE) begin
        step_cnt = count_out - 1'b1;
      end else if (!saturate) begin
        step_cnt  = rollover_val;
        step_wrap = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else if (clear) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else if (load) begin
      count_out     <= load_val;
      rollover_flag <= (load_val == term);
      wrap_pulse    <= 1'b0;
    end else if (do_step && (rollover_val != '0)) begin
      count_out     <= step_cnt;
      rollover_flag <= (step_cnt == term);
      wrap_pulse    <= step_wrap;
    end else begin
      // Hold (including steps ignored while rollover_val is zero): flag keeps its value.
      wrap_pulse    <= 1'b0;
    end
  end

endmodule
